conv_window_gen: RTL and testbench
==================================

CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 Parameter IMAGE_WIDTH, default 8, bits per pixel.
REQ-002 Parameter MATRIX_SIZE, default 3, window edge; only 3 is supported.
REQ-003 Parameter LINE_WIDTH, default 16, pixels per image row; minimum 3.
REQ-004 Parameter LINE_COUNT, default 16, rows per frame; minimum 3.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 in_valid  input  1  in_pixel/in_sof valid.
REQ-008 in_ready  output  1  block accepts the pixel this cycle.
REQ-009 in_pixel  input  IMAGE_WIDTH  raster-order pixel, unsigned.
REQ-010 in_sof  input  1  marks pixel (0,0) of a frame.
REQ-011 out_valid  output  1  out_matrix holds a complete window.
REQ-012 out_ready  input  1  downstream consumer (conv_mat) takes the window.
REQ-013 out_matrix  output  IMAGE_WIDTH*MATRIX_SIZE**2  flattened window; element r*3+c at [(r*3+c)*IMAGE_WIDTH +: IMAGE_WIDTH], r=0 top row, c=0 left column.
REQ-014 out_last  output  1  qualifies the final window of the frame.

Function
REQ-015 Pixel accept = in_valid && in_ready; window transfer = out_valid && out_ready.
REQ-016 in_ready SHALL equal out_ready || !out_valid (single output register, no bubble).
REQ-017 FSM states: S_IDLE, S_RUN; reset enters S_IDLE.
REQ-018 S_IDLE: in_ready=1; accepted pixels without in_sof are discarded; accepted pixel with in_sof is stored as (0,0) and moves FSM to S_RUN.
REQ-019 S_RUN: each accepted pixel advances col 0..LINE_WIDTH-1, wrapping to 0 and incrementing row.
REQ-020 Accepting pixel (LINE_COUNT-1, LINE_WIDTH-1) returns FSM to S_IDLE.
REQ-021 in_sof accepted in S_RUN restarts the frame: pixel stored as (0,0), counters reset, no window produced for it, line-buffer contents from the aborted frame are ignored.
REQ-022 Two line buffers (depth LINE_WIDTH) hold rows r-1 and r-2; 3x3 shift register holds the last three columns of three rows.
REQ-023 Window produced only when the accepted pixel has row>=2 and col>=2 (valid convolution, no padding); window = rows row-2..row, cols col-2..col.
REQ-024 Windows per frame = (LINE_WIDTH-2)*(LINE_COUNT-2).
REQ-025 Latency: out_valid rises the cycle after the accept of the window's bottom-right pixel.
REQ-026 out_valid && !out_ready: out_matrix and out_last held stable; no pixel accepted.
REQ-027 Transfer with no new window in the same cycle clears out_valid; transfer and new window in the same cycle loads the new window, out_valid stays 1.
REQ-028 out_last=1 exactly with the window whose bottom-right pixel is (LINE_COUNT-1, LINE_WIDTH-1).
REQ-029 Windows never span a row wrap: shift register columns from the previous row are not emitted at col 0 or 1.

Reset
REQ-030 On rst: FSM=S_IDLE, counters=0, out_valid=0, out_last=0, out_matrix=0.
REQ-031 Reset mid-frame discards the partial frame; line-buffer storage need not be cleared.
REQ-032 in_ready SHALL be 1 in the cycle after reset deasserts.

Structure
REQ-033 Package conv_pkg: IMAGE_WIDTH/MATRIX_SIZE defaults, pixel_t typedef, state enum.
REQ-034 Sub-module line_buffer (depth LINE_WIDTH, width IMAGE_WIDTH, shift-on-enable); two instances.
REQ-035 out_matrix SHALL connect directly to conv_mat in_matrix with no reordering.

Verification (LINE_WIDTH=5, LINE_COUNT=4, pixel=(row<<4)|col)
REQ-036 Full frame, out_ready=1 -> 6 windows; first holds elements 0..8 = 00,01,02,10,11,12,20,21,22, one cycle after pixel (2,2); last = 12,13,14,22,23,24,32,33,34 with out_last=1.
REQ-037 out_ready=0 for 5 cycles on window 2 -> in_ready=0, out_matrix stable, no pixel lost; window sequence identical to REQ-036.
REQ-038 10 pixels without in_sof before frame -> all discarded; output identical to REQ-036.
REQ-039 in_sof reasserted at pixel (2,3) -> frame restarts; exactly 6 windows from new frame, none mixing old data.
REQ-040 rst for 1 cycle at pixel (3,1) -> out_valid=0 next cycle; next in_sof frame yields REQ-036 output.
REQ-041 Random in_valid/out_ready throttling over 3 frames -> window stream matches software reference model.

Source files
------------

// File: rtl/conv_pkg.sv
// Purpose: shared types and defaults for the 3x3 convolution window generator.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package conv_pkg;

  localparam int DEF_IMAGE_WIDTH = 8;
  localparam int DEF_MATRIX_SIZE = 3;

  typedef logic [DEF_IMAGE_WIDTH-1:0] pixel_t;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

endpackage

// File: rtl/conv_window_gen_if.sv
// Purpose: pixel-in / window-out handshake bundle for conv_window_gen.
// Latency: n/a (wiring only).
// Backpressure: in_ready from the block, out_ready from the window consumer.
// Ports: in_valid/in_ready/in_pixel/in_sof (pixel stream),
//        out_valid/out_ready/out_matrix/out_last (window stream).
// Modports: slave = the window generator, master = the pixel source / window sink.
interface conv_window_gen_if
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH = DEF_IMAGE_WIDTH,
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE
);

  logic                                       in_valid;
  logic                                       in_ready;
  logic [IMAGE_WIDTH-1:0]                     in_pixel;
  logic                                       in_sof;
  logic                                       out_valid;
  logic                                       out_ready;
  logic [IMAGE_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] out_matrix;
  logic                                       out_last;

  modport slave (
    input  in_valid, in_pixel, in_sof, out_ready,
    output in_ready, out_valid, out_matrix, out_last
  );

  modport master (
    output in_valid, in_pixel, in_sof, out_ready,
    input  in_ready, out_valid, out_matrix, out_last
  );

endinterface

// File: rtl/line_buffer.sv
// Purpose: one image row of delay; dout is the pixel pushed DEPTH enables ago.
// Latency: DEPTH enabled shifts from din to dout.
// Backpressure: none; the caller gates en with its own accept.
// Ports: clk, en (shift), din (incoming pixel), dout (oldest stored pixel).
module line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = DEF_IMAGE_WIDTH
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Storage is deliberately not reset: stale contents are never emitted
  // because windows need two freshly written rows first.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Purpose: turn a raster pixel stream into 3x3 valid-convolution windows.
// Latency: window registered one cycle after its bottom-right pixel is accepted.
// Backpressure: in_ready = out_ready || !out_valid; a stalled window holds the input.
// Ports: clk, rst (sync, active-high), bus (conv_window_gen_if.slave).
module conv_window_gen
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH = DEF_IMAGE_WIDTH,
  parameter int MATRIX_SIZE = DEF_MATRIX_SIZE,
  parameter int LINE_WIDTH  = 16,
  parameter int LINE_COUNT  = 16
) (
  input  logic               clk,
  input  logic               rst,
  conv_window_gen_if.slave   bus
);

  localparam int CW = $clog2(LINE_WIDTH);
  localparam int RW = $clog2(LINE_COUNT);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(LINE_COUNT - 1);
  localparam int NEWEST = MATRIX_SIZE - 1;

  state_t                 state;
  logic [CW-1:0]          col;
  logic [RW-1:0]          row;
  logic [CW-1:0]          cur_col;
  logic [RW-1:0]          cur_row;
  logic                   accept;
  logic                   take;
  logic                   emit;
  logic                   at_last;
  logic                   out_valid_q;
  logic                   out_last_q;
  logic [IMAGE_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] out_mat_q;
  logic [IMAGE_WIDTH-1:0] lb0_dout;
  logic [IMAGE_WIDTH-1:0] lb1_dout;

  // Two older columns per row; the third (rightmost) column is the one
  // arriving with the current pixel, so together they form the 3x3 window.
  logic [IMAGE_WIDTH-1:0] win     [MATRIX_SIZE][MATRIX_SIZE-1];
  logic [IMAGE_WIDTH-1:0] col_new [MATRIX_SIZE];

  assign bus.in_ready   = bus.out_ready || !out_valid_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_matrix = out_mat_q;

  assign accept = bus.in_valid && bus.in_ready;
  // An in_sof pixel is always (0,0), from idle or as a mid-frame restart.
  assign take    = accept && (bus.in_sof || state == S_RUN);
  assign cur_col = bus.in_sof ? '0 : col;
  assign cur_row = bus.in_sof ? '0 : row;
  // Requiring col>=2 keeps previous-row columns out of every window.
  assign emit    = take && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  assign at_last = (cur_row == ROW_LAST) && (cur_col == COL_LAST);

  // Row r-2 on top, row r-1 in the middle, the live pixel at the bottom.
  assign col_new[0] = lb1_dout;
  assign col_new[1] = lb0_dout;
  assign col_new[2] = bus.in_pixel;

  line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(IMAGE_WIDTH)) u_lb_prev (
    .clk  (clk),
    .en   (take),
    .din  (bus.in_pixel),
    .dout (lb0_dout)
  );

  line_buffer #(.DEPTH(LINE_WIDTH), .WIDTH(IMAGE_WIDTH)) u_lb_prev2 (
    .clk  (clk),
    .en   (take),
    .din  (lb0_dout),
    .dout (lb1_dout)
  );

  always_ff @(posedge clk) begin
    if (take) begin
      for (int r = 0; r < MATRIX_SIZE; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= col_new[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      row         <= '0;
      col         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_mat_q   <= '0;
    end else begin
      if (take) begin
        if (cur_col == COL_LAST) begin
          col <= '0;
          if (cur_row == ROW_LAST) begin
            row   <= '0;
            state <= S_IDLE;
          end else begin
            row   <= cur_row + 1'b1;
            state <= S_RUN;
          end
        end else begin
          col   <= cur_col + 1'b1;
          row   <= cur_row;
          state <= S_RUN;
        end
      end

      // emit implies accept, which implies the output slot is free or draining.
      if (emit) begin
        out_valid_q <= 1'b1;
        out_last_q  <= at_last;
        for (int r = 0; r < MATRIX_SIZE; r++) begin
          for (int c = 0; c < MATRIX_SIZE; c++) begin
            out_mat_q[(r*MATRIX_SIZE+c)*IMAGE_WIDTH +: IMAGE_WIDTH] <=
              (c == NEWEST) ? col_new[r] : win[r][c];
          end
        end
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Purpose: randomized scoreboard bench for conv_window_gen (5x4 frames).
// Latency: checks each window appears one cycle after its bottom-right pixel.
// Backpressure: throttles out_ready and in_valid, checks hold and in_ready rule.
module tb_conv_window_gen;

  localparam int IW = 8;
  localparam int LW = 5;
  localparam int LC = 4;
  localparam int MW = IW * 9;

  typedef logic [MW:0] ent_t;   // {last, matrix}

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_window_gen_if #(.IMAGE_WIDTH(IW), .MATRIX_SIZE(3)) bus ();

  conv_window_gen #(
    .IMAGE_WIDTH (IW),
    .MATRIX_SIZE (3),
    .LINE_WIDTH  (LW),
    .LINE_COUNT  (LC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ent_t exp_q[$];
  ent_t got_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_pop = 0;

  // Reference model state: frame image and raster position.
  bit         m_run = 0;
  int         m_r = 0;
  int         m_c = 0;
  logic [7:0] img [LC][LW];

  int stall_pct = 0;
  int gap_pct   = 0;
  bit stall_req = 0;
  int stall_at  = 0;
  int stall_cnt = 0;

  logic [MW-1:0] k_first = {8'h22, 8'h21, 8'h20, 8'h12, 8'h11, 8'h10, 8'h02, 8'h01, 8'h00};
  logic [MW-1:0] k_last  = {8'h34, 8'h33, 8'h32, 8'h24, 8'h23, 8'h22, 8'h14, 8'h13, 8'h12};
  logic [MW-1:0] k_hi    = {9{8'h80}};

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic model_accept(input logic [7:0] p, input logic s, output bit produced,
                              output ent_t w);
    produced = 0;
    w = '0;
    if (s) begin
      m_run = 1;
      m_r = 0;
      m_c = 0;
    end else if (!m_run) begin
      return;
    end
    img[m_r][m_c] = p;
    if (m_r >= 2 && m_c >= 2) begin
      produced = 1;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w[(i*3+j)*IW +: IW] = img[m_r-2+i][m_c-2+j];
      w[MW] = (m_r == LC-1 && m_c == LW-1);
      exp_q.push_back(w);
    end
    m_c++;
    if (m_c == LW) begin
      m_c = 0;
      m_r++;
      if (m_r == LC) begin
        m_r = 0;
        m_run = 0;
      end
    end
  endtask

  task automatic send(input logic [7:0] p, input logic s);
    bit   done = 0;
    bit   prod = 0;
    ent_t w;
    int   guard = 0;
    while ($urandom_range(99) < gap_pct) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_pixel = p;
    bus.in_sof   = s;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        model_accept(p, s, prod, w);
        done = 1;
      end
      @(posedge clk); #1;
      if (done && prod)
        chk("latency", {7'b0, bus.out_valid, bus.out_matrix}, {7'b0, 1'b1, w[MW-1:0]});
      if (!done) begin
        guard++;
        if (guard > 1000) begin
          n_cmp++;
          n_fail++;
          $display("FAIL accept_timeout: pixel %h not accepted, required within 1000 cycles", p);
          done = 1;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] off);
    for (int r = 0; r < LC; r++)
      for (int c = 0; c < LW; c++)
        send(8'(r*16 + c) + off, (r == 0 && c == 0));
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(posedge clk); #1;
      g++;
    end
    chk("drain_pending", 80'(exp_q.size()), 80'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int base, input int cnt,
                             input int first_idx, input logic [MW-1:0] off);
    chk({tag, "_count"}, 80'(got_q.size() - base), 80'(cnt));
    if (got_q.size() >= base + cnt) begin
      chk({tag, "_first"}, 80'(got_q[base+first_idx]), 80'({1'b0, k_first | off}));
      chk({tag, "_last"},  80'(got_q[base+cnt-1]),     80'({1'b1, k_last | off}));
    end
  endtask

  // out_ready driver: random throttle, plus an optional 5-cycle stall on one window.
  always @(posedge clk) begin
    #1;
    if (stall_req && bus.out_valid && n_pop == stall_at && stall_cnt < 5) begin
      bus.out_ready = 1'b0;
      stall_cnt++;
    end else begin
      bus.out_ready = ($urandom_range(99) >= stall_pct);
    end
  end

  // Monitor: scoreboard pops on every transfer, plus hold and in_ready rules.
  logic [MW-1:0] prev_mat;
  logic          prev_last;
  bit            prev_stall = 0;

  always @(negedge clk) begin
    ent_t w;
    if (rst) begin
      prev_stall = 0;
    end else begin
      chk("in_ready_rule", 80'(bus.in_ready), 80'(bus.out_ready || !bus.out_valid));
      if (prev_stall)
        chk("hold", {6'b0, bus.out_valid, bus.out_last, bus.out_matrix},
            {6'b0, 1'b1, prev_last, prev_mat});
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_mat   = bus.out_matrix;
      prev_last  = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_window: got %h with none expected",
                   {bus.out_last, bus.out_matrix});
        end else begin
          w = exp_q.pop_front();
          chk("window", 80'({bus.out_last, bus.out_matrix}), 80'(w));
        end
        got_q.push_back({bus.out_last, bus.out_matrix});
        n_pop++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    bus.in_valid = 1'b0;
    bus.in_pixel = '0;
    bus.in_sof   = 1'b0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_out_valid",  80'(bus.out_valid),  80'd0);
    chk("rst_out_last",   80'(bus.out_last),   80'd0);
    chk("rst_out_matrix", 80'(bus.out_matrix), 80'd0);
    chk("rst_in_ready",   80'(bus.in_ready),   80'd1);

    // Plain frame, consumer always ready.
    base = got_q.size();
    send_frame(8'h00);
    drain();
    check_frame("t1", base, 6, 0, '0);

    // Five-cycle stall on the second window of the frame.
    stall_req = 1;
    stall_cnt = 0;
    stall_at  = n_pop + 1;
    base = got_q.size();
    send_frame(8'h00);
    drain();
    stall_req = 0;
    chk("t2_stall_cycles", 80'(stall_cnt), 80'd5);
    check_frame("t2", base, 6, 0, '0);

    // Pixels without in_sof before the frame are discarded.
    base = got_q.size();
    for (int i = 0; i < 10; i++) send(8'($urandom_range(255)), 1'b0);
    send_frame(8'h00);
    drain();
    check_frame("t3", base, 6, 0, '0);

    // in_sof at (2,3): one window from the old frame, then a fresh frame.
    base = got_q.size();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < LW; c++)
        if (r < 2 || c < 3) send(8'(r*16 + c), (r == 0 && c == 0));
    send_frame(8'h80);
    drain();
    check_frame("t4", base, 7, 1, k_hi);
    if (got_q.size() > base)
      chk("t4_old_window", 80'(got_q[base]), 80'({1'b0, k_first}));

    // Reset at (3,1), then a full frame.
    for (int r = 0; r < LC; r++)
      for (int c = 0; c < LW; c++)
        if (r < 3 || c < 1) send(8'(r*16 + c), (r == 0 && c == 0));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    m_run = 0;
    chk("t5_out_valid_after_rst", 80'(bus.out_valid), 80'd0);
    chk("t5_in_ready_after_rst",  80'(bus.in_ready),  80'd1);
    base = got_q.size();
    send_frame(8'h00);
    drain();
    check_frame("t5", base, 6, 0, '0);

    // Random throttling on both sides over three random-content frames.
    stall_pct = 40;
    gap_pct   = 30;
    base = got_q.size();
    for (int f = 0; f < 3; f++) begin
      int junk = $urandom_range(3);
      for (int j = 0; j < junk; j++) send(8'($urandom_range(255)), 1'b0);
      for (int r = 0; r < LC; r++)
        for (int c = 0; c < LW; c++)
          send(8'($urandom_range(255)), (r == 0 && c == 0));
    end
    drain();
    chk("t6_count", 80'(got_q.size() - base), 80'd18);
    stall_pct = 0;
    gap_pct   = 0;
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
